// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
// Shared constants and types for the SPI mode-0 register-file responder.
//   CMD_WRITE / CMD_READ : command bytes understood by the responder
//   CMD_BITS / ADDR_BITS : widths of the command and address header fields
//   state_e              : frame-decoder states
//   is_valid_cmd()       : true for any command the responder acts on
// ---------------------------------------------------------------------------
package spi_slave_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h03;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    IGNORE
  } state_e;

  function automatic logic is_valid_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// ---------------------------------------------------------------------------
// spi_pin_sync
// Brings the asynchronous SPI pins into the i_clk domain and turns the
// synchronized serial clock and chip select into one-cycle event pulses.
//   i_clk, i_rst      : system clock, synchronous active-high reset
//   i_sck, i_cs_n     : raw serial clock and chip select from the master
//   i_mosi            : raw serial data from the master
//   o_cs_n, o_mosi    : synchronized chip select and data
//   o_sck_rise/_fall  : one-cycle pulses on synchronized SCK edges
//   o_cs_rise/_fall   : one-cycle pulses on synchronized CS edges
// ---------------------------------------------------------------------------
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sck,
  input  logic i_cs_n,
  input  logic i_mosi,
  output logic o_cs_n,
  output logic o_mosi,
  output logic o_sck_rise,
  output logic o_sck_fall,
  output logic o_cs_rise,
  output logic o_cs_fall
);

  logic [SYNC_STAGES-1:0] r_sck;
  logic [SYNC_STAGES-1:0] r_cs;
  logic [SYNC_STAGES-1:0] r_mosi;
  logic                   r_sckPrev;
  logic                   r_csPrev;

  // CS resets high so a reset never looks like a frame start by itself;
  // the "previous" flops hold the last synchronized value for edge detection,
  // which makes an action land SYNC_STAGES+1 cycles after the pin edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sck     <= '0;
      r_cs      <= '1;
      r_mosi    <= '0;
      r_sckPrev <= 1'b0;
      r_csPrev  <= 1'b1;
    end else begin
      r_sck     <= {r_sck[SYNC_STAGES-2:0], i_sck};
      r_cs      <= {r_cs[SYNC_STAGES-2:0], i_cs_n};
      r_mosi    <= {r_mosi[SYNC_STAGES-2:0], i_mosi};
      r_sckPrev <= r_sck[SYNC_STAGES-1];
      r_csPrev  <= r_cs[SYNC_STAGES-1];
    end
  end

  assign o_cs_n     = r_cs[SYNC_STAGES-1];
  assign o_mosi     = r_mosi[SYNC_STAGES-1];
  assign o_sck_rise =  r_sck[SYNC_STAGES-1] & ~r_sckPrev;
  assign o_sck_fall = ~r_sck[SYNC_STAGES-1] &  r_sckPrev;
  assign o_cs_rise  =  r_cs[SYNC_STAGES-1]  & ~r_csPrev;
  assign o_cs_fall  = ~r_cs[SYNC_STAGES-1]  &  r_csPrev;

endmodule

// File: rtl/spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile
// SPI mode-0 responder with an internal register file. Frames are
// CMD[7:0], ADDR[7:0], DATA[DATA_W-1:0], MSB first. 0x02 writes, 0x03 reads.
// The SPI pins are oversampled on CLK_I; SPI_CLK is never used as a clock.
//   CLK_I, RST_I     : system clock (>= 8x SPI_CLK), synchronous reset
//   SPI_CLK/CS_N/MOSI: serial interface from the master
//   SPI_MISO(_OE)    : serial read data and its output enable
//   REG_ADR_I        : local debug read address
//   REG_DAT_O        : combinational local read of the register file
//   FRAME_DONE       : pulse when a valid read or write frame completes
//   FRAME_ERR        : pulse on bad command, bad address or aborted frame
// ---------------------------------------------------------------------------
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int NREGS       = 16,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              SPI_CLK,
  input  logic              SPI_CS_N,
  input  logic              SPI_MOSI,
  output logic              SPI_MISO,
  output logic              SPI_MISO_OE,
  input  logic [3:0]        REG_ADR_I,
  output logic [DATA_W-1:0] REG_DAT_O,
  output logic              FRAME_DONE,
  output logic              FRAME_ERR
);

  localparam int          IDX_W     = $clog2(NREGS);
  localparam int          CNT_W     = $clog2(DATA_W);
  localparam logic [31:0] NREGS_U   = NREGS;
  localparam logic [CNT_W-1:0] LAST_CMD  = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

  logic w_csN;
  logic w_mosi;
  logic w_sckRise;
  logic w_sckFall;
  logic w_csRise;
  logic w_csFall;

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [CMD_BITS-2:0]   r_cmd;
  logic [ADDR_BITS-1:0]  r_addr;
  logic [DATA_W-2:0]     r_rx;
  logic [DATA_W-2:0]     r_tx;
  logic                  r_isRead;
  logic                  r_txLoaded;
  logic                  r_miso;
  logic                  r_done;
  logic                  r_err;
  logic [DATA_W-1:0]     r_regs [NREGS];

  logic [CMD_BITS-1:0]   w_cmdNext;
  logic [ADDR_BITS-1:0]  w_addrNext;
  logic [DATA_W-1:0]     w_rxNext;
  logic                  w_addrOk;
  logic [IDX_W-1:0]      w_addrIdx;
  logic [DATA_W-1:0]     w_loadVal;
  logic [IDX_W-1:0]      w_dbgIdx;

  spi_pin_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk      (CLK_I),
    .i_rst      (RST_I),
    .i_sck      (SPI_CLK),
    .i_cs_n     (SPI_CS_N),
    .i_mosi     (SPI_MOSI),
    .o_cs_n     (w_csN),
    .o_mosi     (w_mosi),
    .o_sck_rise (w_sckRise),
    .o_sck_fall (w_sckFall),
    .o_cs_rise  (w_csRise),
    .o_cs_fall  (w_csFall)
  );

  // Shift values including the bit being sampled this cycle, so the last
  // header/data bit is available the moment the counter says "last".
  assign w_cmdNext  = {r_cmd, w_mosi};
  assign w_addrNext = {r_addr[ADDR_BITS-2:0], w_mosi};
  assign w_rxNext   = {r_rx, w_mosi};

  // Addresses beyond the file are flagged; the index is only used when valid.
  assign w_addrOk  = ({{(32-ADDR_BITS){1'b0}}, r_addr} < NREGS_U);
  assign w_addrIdx = r_addr[IDX_W-1:0];
  assign w_loadVal = w_addrOk ? r_regs[w_addrIdx] : '0;

  assign w_dbgIdx  = IDX_W'(REG_ADR_I);
  assign REG_DAT_O = ({28'd0, REG_ADR_I} < NREGS_U) ? r_regs[w_dbgIdx] : '0;

  assign SPI_MISO    = r_miso;
  assign SPI_MISO_OE = ~w_csN;
  assign FRAME_DONE  = r_done;
  assign FRAME_ERR   = r_err;

  // Frame decoder. A CS rise outranks any SCK event in the same cycle and
  // aborts a frame that has started shifting bits. MOSI is taken on SCK
  // rises; MISO only moves on SCK falls so it is stable for the master.
  // tx_shift keeps only the bits below the one already on MISO.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cmd      <= '0;
      r_addr     <= '0;
      r_rx       <= '0;
      r_tx       <= '0;
      r_isRead   <= 1'b0;
      r_txLoaded <= 1'b0;
      r_miso     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (w_csRise) begin
        if ((r_state == CMD && r_cnt != '0) || r_state == ADDR || r_state == DATA) begin
          r_err <= 1'b1;
        end
        r_state    <= IDLE;
        r_cnt      <= '0;
        r_miso     <= 1'b0;
        r_txLoaded <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_csFall) begin
              r_state    <= CMD;
              r_cnt      <= '0;
              r_txLoaded <= 1'b0;
              r_miso     <= 1'b0;
            end
          end
          CMD: begin
            if (w_sckRise) begin
              r_cmd <= w_cmdNext[CMD_BITS-2:0];
              if (r_cnt == LAST_CMD) begin
                r_cnt <= '0;
                if (is_valid_cmd(w_cmdNext)) begin
                  r_isRead <= (w_cmdNext == CMD_READ);
                  r_state  <= ADDR;
                end else begin
                  r_err   <= 1'b1;
                  r_state <= IGNORE;
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          ADDR: begin
            if (w_sckRise) begin
              r_addr <= w_addrNext;
              if (r_cnt == LAST_ADDR) begin
                r_cnt   <= '0;
                r_state <= DATA;
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (w_sckFall && r_isRead) begin
              if (!r_txLoaded) begin
                r_tx       <= w_loadVal[DATA_W-2:0];
                r_miso     <= w_loadVal[DATA_W-1];
                r_txLoaded <= 1'b1;
                if (!w_addrOk) begin
                  r_err <= 1'b1;
                end
              end else begin
                r_tx   <= {r_tx[DATA_W-3:0], 1'b0};
                r_miso <= r_tx[DATA_W-2];
              end
            end
            if (w_sckRise) begin
              r_rx <= w_rxNext[DATA_W-2:0];
              if (r_cnt == LAST_DATA) begin
                r_cnt   <= '0;
                r_state <= IGNORE;
                if (!w_addrOk && !r_isRead) begin
                  r_err <= 1'b1;
                end else if (w_addrOk) begin
                  r_done <= 1'b1;
                  if (!r_isRead) begin
                    r_regs[w_addrIdx] <= w_rxNext;
                  end
                end
              end else begin
                r_cnt <= r_cnt + 1'b1;
              end
            end
          end
          IGNORE: begin
            r_miso <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_regfile
// Drives directed SPI mode-0 frames at CLK_I/8 into spi_slave_regfile.
// Expected FRAME_DONE/FRAME_ERR pulses and expected MISO read words are
// queued when a frame is issued; monitor processes pop and compare them
// when the DUT pulses or when a read word has been shifted out.
// ---------------------------------------------------------------------------
module tb_spi_slave_regfile;

  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;
  localparam int EV_BOTH = 3;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        SPI_CLK;
  logic        SPI_CS_N;
  logic        SPI_MOSI;
  logic        SPI_MISO;
  logic        SPI_MISO_OE;
  logic [3:0]  REG_ADR_I;
  logic [31:0] REG_DAT_O;
  logic        FRAME_DONE;
  logic        FRAME_ERR;

  int          checks   = 0;
  int          failures = 0;
  int          expEvents[$];
  logic [31:0] expRead[$];
  logic [31:0] capturedWord;
  event        readCaptured;

  spi_slave_regfile #(
    .NREGS       (16),
    .DATA_W      (32),
    .SYNC_STAGES (2)
  ) dut (
    .CLK_I       (CLK_I),
    .RST_I       (RST_I),
    .SPI_CLK     (SPI_CLK),
    .SPI_CS_N    (SPI_CS_N),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_MISO    (SPI_MISO),
    .SPI_MISO_OE (SPI_MISO_OE),
    .REG_ADR_I   (REG_ADR_I),
    .REG_DAT_O   (REG_DAT_O),
    .FRAME_DONE  (FRAME_DONE),
    .FRAME_ERR   (FRAME_ERR)
  );

  // 100 MHz system clock.
  always #5 CLK_I = ~CLK_I;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Half an SPI clock period: four CLK_I cycles, inputs change on negedge.
  task automatic halfPeriod();
    repeat (4) @(negedge CLK_I);
  endtask

  // Shifts nBits of {cmd, addr, data} MSB first. MISO is sampled by the
  // master at each rising SCK during the data phase. endFrame raises CS
  // afterwards; captureMiso hands the 32 sampled bits to the read monitor.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] addr,
                               input logic [31:0] data, input int nBits,
                               input bit endFrame, input bit captureMiso);
    logic [47:0] frame;
    logic [31:0] cap;
    frame = {cmd, addr, data};
    cap   = '0;
    @(negedge CLK_I);
    SPI_CS_N = 1'b0;
    for (int i = 0; i < nBits; i++) begin
      SPI_MOSI = frame[47-i];
      halfPeriod();
      SPI_CLK = 1'b1;
      if (i >= 16) begin
        cap = {cap[30:0], SPI_MISO};
      end
      halfPeriod();
      SPI_CLK = 1'b0;
    end
    if (captureMiso) begin
      capturedWord = cap;
      ->readCaptured;
    end
    if (endFrame) begin
      halfPeriod();
      SPI_CS_N = 1'b1;
      SPI_MOSI = 1'b0;
      repeat (10) @(negedge CLK_I);
    end
  endtask

  // Event monitor: every FRAME_DONE/FRAME_ERR pulse must match the next
  // expected event.
  initial begin
    forever begin
      int kind;
      @(negedge CLK_I);
      if (!RST_I && (FRAME_DONE || FRAME_ERR)) begin
        kind = (FRAME_DONE && FRAME_ERR) ? EV_BOTH : (FRAME_DONE ? EV_DONE : EV_ERR);
        if (expEvents.size() == 0) begin
          checkOutput("unexpected frame event", kind, 0);
        end else begin
          checkOutput("frame event kind", kind, expEvents.pop_front());
        end
      end
    end
  end

  // Read monitor: every word shifted out on MISO must match the next
  // expected read word.
  initial begin
    forever begin
      @(readCaptured);
      if (expRead.size() == 0) begin
        checkOutput("unexpected miso word", 1, 0);
      end else begin
        checkOutput("miso word", capturedWord, expRead.pop_front());
      end
    end
  end

  initial begin
    RST_I     = 1'b1;
    SPI_CLK   = 1'b0;
    SPI_CS_N  = 1'b1;
    SPI_MOSI  = 1'b0;
    REG_ADR_I = 4'd0;
    repeat (3) @(negedge CLK_I);

    checkOutput("reset miso", {31'd0, SPI_MISO}, 0);
    checkOutput("reset miso_oe", {31'd0, SPI_MISO_OE}, 0);
    checkOutput("reset frame_done", {31'd0, FRAME_DONE}, 0);
    checkOutput("reset frame_err", {31'd0, FRAME_ERR}, 0);
    checkOutput("reset reg0", REG_DAT_O, 32'h0);
    RST_I = 1'b0;
    repeat (5) @(negedge CLK_I);

    // Valid write to register 5.
    expEvents.push_back(EV_DONE);
    applyStimulus(8'h02, 8'h05, 32'hDEADBEEF, 48, 1'b1, 1'b0);
    REG_ADR_I = 4'd5;
    #1 checkOutput("reg5 after write", REG_DAT_O, 32'hDEADBEEF);

    // Read it back over MISO.
    expEvents.push_back(EV_DONE);
    expRead.push_back(32'hDEADBEEF);
    applyStimulus(8'h03, 8'h05, 32'h0, 48, 1'b1, 1'b1);

    // Bad command: error after the command byte, MISO stays low, no write.
    expEvents.push_back(EV_ERR);
    expRead.push_back(32'h0);
    applyStimulus(8'hA5, 8'h05, 32'hFFFFFFFF, 48, 1'b1, 1'b1);
    REG_ADR_I = 4'd5;
    #1 checkOutput("reg5 after bad cmd", REG_DAT_O, 32'hDEADBEEF);

    // Out-of-range write is dropped (0x20 must not alias onto register 0).
    expEvents.push_back(EV_ERR);
    applyStimulus(8'h02, 8'h20, 32'hCAFEF00D, 48, 1'b1, 1'b0);
    REG_ADR_I = 4'd0;
    #1 checkOutput("reg0 after bad addr write", REG_DAT_O, 32'h0);

    // Out-of-range read returns zeros and flags an error.
    expEvents.push_back(EV_ERR);
    expRead.push_back(32'h0);
    applyStimulus(8'h03, 8'h20, 32'h0, 48, 1'b1, 1'b1);

    // Write to register 3 aborted after 20 data bits.
    expEvents.push_back(EV_ERR);
    applyStimulus(8'h02, 8'h03, 32'hA5A5A5A5, 36, 1'b1, 1'b0);
    REG_ADR_I = 4'd3;
    #1 checkOutput("reg3 after abort", REG_DAT_O, 32'h0);

    // Full write to register 3 then succeeds, and reads back.
    expEvents.push_back(EV_DONE);
    applyStimulus(8'h02, 8'h03, 32'h12345678, 48, 1'b1, 1'b0);
    REG_ADR_I = 4'd3;
    #1 checkOutput("reg3 after write", REG_DAT_O, 32'h12345678);
    expEvents.push_back(EV_DONE);
    expRead.push_back(32'h12345678);
    applyStimulus(8'h03, 8'h03, 32'h0, 48, 1'b1, 1'b1);

    // Reset in the middle of a read of register 5.
    applyStimulus(8'h03, 8'h05, 32'h0, 26, 1'b0, 1'b0);
    @(negedge CLK_I);
    RST_I = 1'b1;
    @(negedge CLK_I);
    RST_I = 1'b0;
    checkOutput("miso after mid-frame reset", {31'd0, SPI_MISO}, 0);
    checkOutput("miso_oe after mid-frame reset", {31'd0, SPI_MISO_OE}, 0);
    for (int r = 0; r < 16; r++) begin
      REG_ADR_I = 4'(r);
      #1 checkOutput($sformatf("reg%0d after reset", r), REG_DAT_O, 32'h0);
    end
    @(negedge CLK_I);
    SPI_CS_N = 1'b1;
    repeat (10) @(negedge CLK_I);

    // Fresh read of register 5 now returns zero.
    expEvents.push_back(EV_DONE);
    expRead.push_back(32'h0);
    applyStimulus(8'h03, 8'h05, 32'h0, 48, 1'b1, 1'b1);

    repeat (10) @(negedge CLK_I);
    checkOutput("pending frame events", expEvents.size(), 0);
    checkOutput("pending miso words", expRead.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
